// File: rtl/output_backprop_bank.sv
// output_backprop_bank
//   Output-layer weight-update engine. Holds NUM_HIDDEN hidden->output
//   weights and, on an accepted start, sweeps them one per cycle through a
//   two-stage pipeline:
//     w[k] <= fit(w[k] - ((2 * (final - target) * h[k]) >>> LR_SHIFT))
//   Optional feature macro: OBP_SATURATE_EN
//     defined   : fit() clamps to the W_W signed range and sets sticky sat_o
//     undefined : fit() wraps (keeps low W_W bits), sat_o tied 0
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   start_i               begin sweep (sampled in IDLE only)
//   x_i, final_i          target / network output, captured on start accept
//   hidden_vals_i         h[k] at [k*H_W +: H_W], held stable during a sweep
//   zero_weight_reset_i   sync clear of all weights, aborts a sweep
//   wr_en_i/addr/data     weight load port (IDLE only)
//   weights_o             w[k] at [k*W_W +: W_W]
//   busy_o, done_o        sweep in progress / one-cycle completion pulse
//   sat_o                 sticky saturation flag
module output_backprop_bank #(
   parameter int NUM_HIDDEN = 4,
   parameter int H_W        = 10,
   parameter int FINAL_W    = 19,
   parameter int TGT_W      = 4,
   parameter int W_W        = 8,
   parameter int LR_SHIFT   = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [TGT_W-1:0]                x_i,
   input  logic [FINAL_W-1:0]              final_i,
   input  logic [NUM_HIDDEN*H_W-1:0]       hidden_vals_i,
   input  logic                            zero_weight_reset_i,
   input  logic                            wr_en_i,
   input  logic [$clog2(NUM_HIDDEN)-1:0]   wr_addr_i,
   input  logic [W_W-1:0]                  wr_data_i,
   output logic [NUM_HIDDEN*W_W-1:0]       weights_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            sat_o
);

   localparam int AW = $clog2(NUM_HIDDEN);
   localparam int EW = FINAL_W + 1;          // signed error width
   localparam int FW = FINAL_W + H_W + 3;    // full-precision datapath width

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                 r_state;
   logic                   r_busy;
   logic                   r_done;
   logic [AW-1:0]          r_idx_p0;
   logic signed [EW-1:0]   r_err_p0;
   logic signed [FW-1:0]   r_prod_p1;
   logic [AW-1:0]          r_idx_p1;
   logic                   r_vld_p1;
   logic signed [W_W-1:0]  r_w [NUM_HIDDEN];

   logic signed [EW-1:0]   w_err_p0;
   logic [H_W-1:0]         w_h_sel;
   logic signed [FW-1:0]   w_prod_p0;
   logic signed [W_W-1:0]  w_w_sel;
   logic signed [FW-1:0]   w_grad;
   logic signed [FW-1:0]   w_delta;
   logic signed [FW-1:0]   w_diff;

`ifdef OBP_SATURATE_EN
   localparam logic signed [FW-1:0] W_MAX = FW'((2 ** (W_W - 1)) - 1);
   localparam logic signed [FW-1:0] W_MIN = ~W_MAX;

   logic r_sat;

   function automatic logic signed [W_W-1:0] fit(input logic signed [FW-1:0] v);
      if (v > W_MAX)      return W_MAX[W_W-1:0];
      else if (v < W_MIN) return W_MIN[W_W-1:0];
      else                return v[W_W-1:0];
   endfunction

   function automatic logic clamps(input logic signed [FW-1:0] v);
      return (v > W_MAX) || (v < W_MIN);
   endfunction

   assign sat_o = r_sat;
`else
   logic w_unused_hi;

   function automatic logic signed [W_W-1:0] fit(input logic signed [FW-1:0] v);
      return v[W_W-1:0];
   endfunction

   // Wrap mode deliberately discards the bits above the weight width.
   assign w_unused_hi = ^w_diff[FW-1:W_W];
   assign sat_o       = 1'b0;
`endif

   // Both operands are below 2^FINAL_W, so the EW-bit difference is an exact
   // two's-complement error.
   assign w_err_p0 = {1'b0, final_i} - EW'(x_i);

   always_comb begin
      w_h_sel = '0;
      for (int k = 0; k < NUM_HIDDEN; k++)
         if (r_idx_p0 == AW'(k)) w_h_sel = hidden_vals_i[k*H_W +: H_W];
   end

   always_comb begin
      w_w_sel = '0;
      for (int k = 0; k < NUM_HIDDEN; k++)
         if (r_idx_p1 == AW'(k)) w_w_sel = r_w[k];
   end

   // Stage 1: signed error times zero-extended activation
   assign w_prod_p0 = {{(FW-EW){r_err_p0[EW-1]}}, r_err_p0} * $signed({{(FW-H_W){1'b0}}, w_h_sel});

   // Stage 2: gradient, floor shift, weight update
   assign w_grad  = r_prod_p1 <<< 1;
   assign w_delta = w_grad >>> LR_SHIFT;
   assign w_diff  = {{(FW-W_W){w_w_sel[W_W-1]}}, w_w_sel} - w_delta;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_idx_p0 <= '0;
         r_vld_p1 <= 1'b0;
      end else if (zero_weight_reset_i) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_idx_p0 <= '0;
         r_vld_p1 <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_vld_p1 <= (r_state == S_RUN);
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state  <= S_RUN;
                  r_busy   <= 1'b1;
                  r_idx_p0 <= '0;
               end
            end
            S_RUN: begin
               r_idx_p0 <= r_idx_p0 + AW'(1);
               if (r_idx_p0 == AW'(NUM_HIDDEN - 1)) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if ((r_state == S_IDLE) && start_i) r_err_p0 <= w_err_p0;
      if (r_state == S_RUN) begin
         r_prod_p1 <= w_prod_p0;
         r_idx_p1  <= r_idx_p0;
      end
   end

   // Pipeline writes and load-port writes never coincide: the pipeline is
   // valid only in RUN/DRAIN, the load port only acts in IDLE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_HIDDEN; k++) r_w[k] <= '0;
`ifdef OBP_SATURATE_EN
         r_sat <= 1'b0;
`endif
      end else if (zero_weight_reset_i) begin
         for (int k = 0; k < NUM_HIDDEN; k++) r_w[k] <= '0;
`ifdef OBP_SATURATE_EN
         r_sat <= 1'b0;
`endif
      end else if (r_vld_p1) begin
         r_w[r_idx_p1] <= fit(w_diff);
`ifdef OBP_SATURATE_EN
         if (clamps(w_diff)) r_sat <= 1'b1;
`endif
      end else if ((r_state == S_IDLE) && wr_en_i && (32'(wr_addr_i) < NUM_HIDDEN)) begin
         r_w[wr_addr_i] <= wr_data_i;
      end
   end

   for (genvar gk = 0; gk < NUM_HIDDEN; gk++) begin : g_wout
      assign weights_o[gk*W_W +: W_W] = r_w[gk];
   end

   assign busy_o = r_busy;
   assign done_o = r_done;

endmodule

// File: tb/tb_output_backprop_bank.sv
module tb_output_backprop_bank;

   localparam int N       = 4;
   localparam int H_W     = 10;
   localparam int FINAL_W = 19;
   localparam int TGT_W   = 7;
   localparam int W_W     = 8;
   localparam int LR      = 4;
   localparam int AW      = $clog2(N);

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [TGT_W-1:0]     x;
   logic [FINAL_W-1:0]   fin;
   logic [N*H_W-1:0]     hid;
   logic                 zwr;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [W_W-1:0]       wr_data;
   logic [N*W_W-1:0]     weights;
   logic                 busy;
   logic                 done;
   logic                 sat;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   output_backprop_bank #(
      .NUM_HIDDEN(N), .H_W(H_W), .FINAL_W(FINAL_W), .TGT_W(TGT_W), .W_W(W_W), .LR_SHIFT(LR)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x), .final_i(fin),
      .hidden_vals_i(hid), .zero_weight_reset_i(zwr), .wr_en_i(wr_en),
      .wr_addr_i(wr_addr), .wr_data_i(wr_data), .weights_o(weights),
      .busy_o(busy), .done_o(done), .sat_o(sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Sweep progress is tracked as the number of clock edges since the start
   // was accepted: weight k lands on edge k+2, done is visible after edge N+1,
   // the bank is idle again after edge N+2.
   longint m_w [N];
   longint m_err;
   int     m_cnt = -1;
   bit     m_sat = 1'b0;

   function automatic longint floor_div(input longint a, input longint b);
      longint q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint fit_model(input longint v);
      longint lo = -(longint'(1) << (W_W - 1));
`ifdef OBP_SATURATE_EN
      if (v > -lo - 1) begin m_sat = 1'b1; return -lo - 1; end
      if (v < lo)      begin m_sat = 1'b1; return lo; end
      return v;
`else
      return ((v - lo) & ((longint'(1) << W_W) - 1)) + lo;
`endif
   endfunction

   function automatic void apply_update(input int k);
      longint h = longint'(hid[k*H_W +: H_W]);
      m_w[k] = fit_model(m_w[k] - floor_div(2 * m_err * h, longint'(1) << LR));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst || zwr) begin
         for (int k = 0; k < N; k++) m_w[k] = 0;
         m_cnt = -1;
         m_sat = 1'b0;
      end else if (m_cnt >= 0) begin
         m_cnt++;
         if (m_cnt >= 2 && m_cnt <= N + 1) apply_update(m_cnt - 2);
         if (m_cnt == N + 2) m_cnt = -1;
      end else begin
         if (wr_en && int'(wr_addr) < N) m_w[wr_addr] = longint'($signed(wr_data));
         if (start) begin
            m_err = longint'(fin) - longint'(x);
            m_cnt = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < N; k++)
            check($sformatf("w%0d", k), longint'($signed(weights[k*W_W +: W_W])), m_w[k]);
         check("busy", longint'(busy), longint'(m_cnt >= 0));
         check("done", longint'(done), longint'(m_cnt == N + 1));
         check("sat", longint'(sat), longint'(m_sat));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_w(input int k, input int val);
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = W_W'(val);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic set_h(input int v);
      for (int k = 0; k < N; k++) hid[k*H_W +: H_W] = H_W'(v);
   endtask

   // Accept a sweep, then watch 12 cycles. start_mask bit i pulses a junk
   // start after edge i; wr_mask bit i drives a load to w2 after edge i.
   task automatic run_sweep(input int xv, input int fv, input int start_mask,
                            input int wr_mask, output int nd, output int dpos);
      nd = 0; dpos = -1;
      x = TGT_W'(xv); fin = FINAL_W'(fv); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (done) begin nd++; dpos = i; end
         start = start_mask[i];
         if (start_mask[i]) begin x = '1; fin = 7; end
         wr_en = wr_mask[i]; wr_addr = 2; wr_data = 55;
      end
      start = 1'b0; wr_en = 1'b0;
   endtask

   int nd, dpos;

   initial begin
      rst = 1'b1; start = 1'b0; x = '0; fin = '0; hid = '0; zwr = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      @(negedge clk); @(negedge clk);
      check("rst_weights", longint'(weights), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_sat", longint'(sat), 0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // 1: err=2, h=8 -> delta 2
      for (int k = 0; k < N; k++) load_w(k, 10);
      set_h(8);
      run_sweep(3, 5, 0, 0, nd, dpos);
      check("t1_done_count", nd, 1);
      check("t1_done_pos", dpos, N + 1);
      for (int k = 0; k < N; k++)
         check($sformatf("t1_w%0d", k), longint'($signed(weights[k*W_W +: W_W])), 8);

      // 2: err=-2 -> delta -2
      for (int k = 0; k < N; k++) load_w(k, 10);
      run_sweep(5, 3, 0, 0, nd, dpos);
      for (int k = 0; k < N; k++)
         check($sformatf("t2_w%0d", k), longint'($signed(weights[k*W_W +: W_W])), 12);

      // 3: overflow of w0 (delta -200)
      load_w(0, 120);
      hid = '0; hid[0 +: H_W] = 16;
      run_sweep(100, 0, 0, 0, nd, dpos);
`ifdef OBP_SATURATE_EN
      check("t3_w0", longint'($signed(weights[0 +: W_W])), 127);
      check("t3_sat", longint'(sat), 1);
`else
      check("t3_w0", longint'($signed(weights[0 +: W_W])), 64);
      check("t3_sat", longint'(sat), 0);
`endif

      // 4: start pulses mid-sweep and in DONE are ignored
      for (int k = 0; k < N; k++) load_w(k, 10);
      set_h(8);
      run_sweep(3, 5, (1 << 2) | (1 << 5), 0, nd, dpos);
      check("t4_done_count", nd, 1);
      for (int k = 0; k < N; k++)
         check($sformatf("t4_w%0d", k), longint'($signed(weights[k*W_W +: W_W])), 8);

      // 5a: zero_weight_reset_i during the 2nd RUN cycle
      for (int k = 0; k < N; k++) load_w(k, 10);
      x = 3; fin = 5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      zwr = 1'b1;
      @(negedge clk);
      zwr = 1'b0;
      check("t5_zwr_weights", longint'(weights), 0);
      check("t5_zwr_busy", longint'(busy), 0);
      check("t5_zwr_sat", longint'(sat), 0);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("t5_zwr_no_done", nd, 0);

      // 5b: asynchronous reset mid-sweep
      for (int k = 0; k < N; k++) load_w(k, 10);
      x = 3; fin = 5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_weights", longint'(weights), 0);
      check("t5_rst_busy", longint'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 6: load with start on the same edge; load while busy is dropped
      set_h(8);
      wr_en = 1'b1; wr_addr = 1; wr_data = W_W'(-4);
      run_sweep(0, 0, 0, (1 << 2), nd, dpos);
      check("t6_w1", longint'($signed(weights[1*W_W +: W_W])), -4);
      check("t6_w2", longint'($signed(weights[2*W_W +: W_W])), 0);
      check("t6_done_count", nd, 1);

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         zwr     = ($urandom_range(0, 59) == 0);
         wr_en   = ($urandom_range(0, 4) == 0);
         wr_addr = AW'($urandom_range(0, N - 1));
         wr_data = W_W'($urandom);
         start   = ($urandom_range(0, 5) == 0);
         x       = TGT_W'($urandom);
         fin     = ($urandom_range(0, 1) == 0) ? FINAL_W'($urandom_range(0, 300)) : FINAL_W'($urandom);
         if (m_cnt < 0)
            for (int k = 0; k < N; k++)
               hid[k*H_W +: H_W] = ($urandom_range(0, 1) == 0) ? H_W'($urandom_range(0, 40)) : H_W'($urandom);
         @(negedge clk);
      end
      zwr = 1'b0; wr_en = 1'b0; start = 1'b0;
      repeat (10) @(negedge clk);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
